fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end with an in-order instruction queue.
//
// Issues word-aligned fetch requests from fetch_pc, allocates a queue slot per
// granted request and fills slots in order as responses return. Decode pops
// the head with a valid/ready handshake. A redirect (or reset) flushes the
// queue and retargets fetch; responses to requests already in flight at that
// moment are discarded by a drop counter instead of being written.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   redirect          flush and refetch from redirect_pc (word aligned)
//   imem_req/addr     fetch request and byte address
//   imem_gnt          memory accepted the request this cycle
//   imem_rvalid/rdata in-order response
//   instr_valid/instr/instr_pc  queue head towards decode
//   instr_ready       decode consumes the head
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;       // counts 0..DEPTH
   localparam int DW = $clog2(2 * DEPTH) + 1;   // drop counter

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } slot_t;

   slot_t [DEPTH-1:0] slot_q, slot_d;
   logic [AW-1:0]     head_q, head_d;
   logic [CW-1:0]     occ_q, occ_d;       // allocated slots, filled or not
   logic [CW-1:0]     nfill_q, nfill_d;   // filled slots, contiguous from head
   logic [DW-1:0]     drop_q, drop_d;
   logic [31:0]       pc_q, pc_d;

   logic              grant, drop_hit, fill, pop;
   logic [AW-1:0]     tail_idx, fill_idx;
   logic [CW-1:0]     unfilled;

   // Request decision uses pre-edge occupancy, so a pop does not free a slot
   // for a request in the same cycle.
   assign imem_req    = !rst && !redirect && (occ_q < CW'(DEPTH));
   assign imem_addr   = pc_q;
   assign grant       = imem_req && imem_gnt;

   // Older (dropped) requests always return before newer ones.
   assign drop_hit    = imem_rvalid && (drop_q != '0);
   assign fill        = imem_rvalid && (drop_q == '0);

   assign instr_valid = (nfill_q != '0);
   assign instr       = instr_valid ? slot_q[head_q].word : 32'h0;
   assign instr_pc    = instr_valid ? slot_q[head_q].pc   : 32'h0;
   assign pop         = instr_valid && instr_ready;

   // Slot index arithmetic wraps naturally because DEPTH is a power of two.
   assign tail_idx    = head_q + occ_q[AW-1:0];
   assign fill_idx    = head_q + nfill_q[AW-1:0];
   assign unfilled    = occ_q - nfill_q;

   always_comb begin
      slot_d  = slot_q;
      head_d  = head_q + AW'(pop);
      occ_d   = occ_q + CW'(grant) - CW'(pop);
      nfill_d = nfill_q + CW'(fill) - CW'(pop);
      drop_d  = drop_q - DW'(drop_hit);
      pc_d    = grant ? pc_q + 32'd4 : pc_q;

      if (grant) slot_d[tail_idx].pc  = pc_q;
      if (fill)  slot_d[fill_idx].word = imem_rdata;

      // Flush: every granted request whose response is not back yet, minus
      // one returning this very cycle, must be discarded when it arrives.
      // Reset does the same since memory keeps answering across our reset.
      if (rst || redirect) begin
         drop_d  = drop_q - DW'(drop_hit) + DW'(unfilled) - DW'(fill);
         head_d  = '0;
         occ_d   = '0;
         nfill_d = '0;
         pc_d    = {redirect_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      slot_q <= slot_d;
      drop_q <= drop_d;
      if (rst) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         occ_q   <= '0;
         nfill_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         occ_q   <= occ_d;
         nfill_q <= nfill_d;
      end
   end

endmodule
